// File: rtl/addsub16_pkg.sv
// Shared types and constants for the nibble-serial 16-bit add/subtract unit.
package addsub16_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int          PKG_WIDTH = 16;
    localparam int          PKG_SLICE = 4;
    localparam int          NSLICE    = PKG_WIDTH / PKG_SLICE;
    localparam logic [15:0] SAT_POS   = 16'h7FFF;
    localparam logic [15:0] SAT_NEG   = 16'h8000;

endpackage

// File: rtl/addsub_slice4.sv
// Combinational 4-bit add/subtract slice; c3 is the carry into bit 3 for overflow detection.
module addsub_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] s,
    output logic       cout,
    output logic       c3
);

    logic [3:0] w_bx;
    logic [3:0] w_low;
    logic [1:0] w_top;

    always_comb begin
        w_bx  = b ^ {4{sub}};
        w_low = {1'b0, a[2:0]} + {1'b0, w_bx[2:0]} + {3'b000, cin};
        c3    = w_low[3];
        w_top = {1'b0, a[3]} + {1'b0, w_bx[3]} + {1'b0, w_low[3]};
        s     = {w_top[0], w_low[2:0]};
        cout  = w_top[1];
    end

endmodule

// File: rtl/nibble_serial_addsub16.sv
// Multi-cycle signed add/subtract: one 4-bit slice iterated LSB-first, saturating result and Z/V/N flags.
// Handshake: start is accepted only on an edge where ready=1; done is a one-cycle pulse with result/flags valid.
module nibble_serial_addsub16
    import addsub16_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SLICE    = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovfl,
    output logic             zero,
    output logic             neg,
    output state_t           dbg_state
);

    localparam int NS   = WIDTH / SLICE;
    localparam int IDXW = $clog2(NS);

    state_t                  r_state;
    logic [WIDTH-1:0]        r_a;
    logic [WIDTH-1:0]        r_b;
    logic                    r_sub;
    logic                    r_carry;
    logic [IDXW-1:0]         r_idx;
    // The top nibble never needs storing: it goes straight into the result.
    logic [WIDTH-SLICE-1:0]  r_work;
    logic [WIDTH-1:0]        r_result;
    logic                    r_ovfl;
    logic                    r_zero;
    logic                    r_neg;

    logic [SLICE-1:0]        w_a_nib;
    logic [SLICE-1:0]        w_b_nib;
    logic [SLICE-1:0]        w_s;
    logic                    w_cout;
    logic                    w_c3;
    logic                    w_last;
    logic                    w_v;
    logic [WIDTH-1:0]        w_full;
    logic [WIDTH-1:0]        w_final;

    always_comb begin
        w_a_nib = r_a[r_idx*SLICE +: SLICE];
        w_b_nib = r_b[r_idx*SLICE +: SLICE];
        w_last  = (r_idx == IDXW'(NS - 1));
        w_v     = w_c3 ^ w_cout;
        w_full  = {w_s, r_work};
        w_final = w_full;
        // Overflow sign follows the latched A: both operands (after inversion) share A's sign.
        if (SATURATE && w_v) begin
            w_final = r_a[WIDTH-1] ? SAT_NEG : SAT_POS;
        end
    end

    addsub_slice4 u_slice (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_carry),
        .sub  (r_sub),
        .s    (w_s),
        .cout (w_cout),
        .c3   (w_c3)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_sub    <= 1'b0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_work   <= '0;
            r_result <= '0;
            r_ovfl   <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_sub   <= sub;
                        r_carry <= sub;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_carry <= w_cout;
                    r_idx   <= r_idx + 1'b1;
                    for (int i = 0; i < NS - 1; i++) begin
                        if (r_idx == IDXW'(i)) begin
                            r_work[i*SLICE +: SLICE] <= w_s;
                        end
                    end
                    if (w_last) begin
                        r_result <= w_final;
                        r_ovfl   <= w_v;
                        r_zero   <= (w_final == '0);
                        r_neg    <= w_final[WIDTH-1];
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready     = (r_state == S_IDLE);
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign result    = r_result;
    assign ovfl      = r_ovfl;
    assign zero      = r_zero;
    assign neg       = r_neg;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_nibble_serial_addsub16.sv
// Bench for nibble_serial_addsub16: vector table, random ops against a wide-arithmetic model, handshake and reset sequences.
module tb_nibble_serial_addsub16;
    import addsub16_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        sub;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        ovfl;
    logic        zero;
    logic        neg;
    state_t      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // {result, ovfl, zero, neg}
    logic [18:0] exp_q[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] res;
        logic        v;
        logic        z;
        logic        n;
    } vec_t;

    vec_t vecs[10];

    nibble_serial_addsub16 #(.WIDTH(16), .SLICE(4), .SATURATE(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .B         (B),
        .sub       (sub),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .ovfl      (ovfl),
        .zero      (zero),
        .neg       (neg),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic signed [16:0] ea;
        logic signed [16:0] eb;
        logic signed [16:0] r;
        logic               v;
        logic [15:0]        res;
        ea  = {a[15], a};
        eb  = {b[15], b};
        r   = s ? (ea - eb) : (ea + eb);
        v   = (r > 17'sd32767) || (r < -17'sd32768);
        res = v ? (a[15] ? 16'h8000 : 16'h7FFF) : r[15:0];
        return {res, v, (res == 16'h0000), res[15]};
    endfunction

    task automatic pop_compare(input string name);
        logic [18:0] e;
        if (exp_q.size() == 0) begin
            chk({name, "_unexpected_done"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_result"}, {16'h0, result}, {16'h0, e[18:3]});
            chk({name, "_ovfl"}, {31'h0, ovfl}, {31'h0, e[2]});
            chk({name, "_zero"}, {31'h0, zero}, {31'h0, e[1]});
            chk({name, "_neg"}, {31'h0, neg}, {31'h0, e[0]});
        end
    endtask

    // driver: one operation, with exact done timing checked edge by edge
    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [18:0] e);
        @(negedge clk);
        chk({name, "_ready_pre"}, {31'h0, ready}, 32'd1);
        A = a; B = b; sub = s; start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        A = 16'($urandom); B = 16'($urandom); sub = 1'($urandom_range(0, 1));
        chk({name, "_busy"}, {31'h0, busy}, 32'd1);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, "_done_t"}, {31'h0, done}, (c == 4) ? 32'd1 : 32'd0);
            if (done) pop_compare(name);
        end
        @(posedge clk);
        @(negedge clk);
        chk({name, "_ready_post"}, {31'h0, ready}, 32'd1);
        chk({name, "_done_post"}, {31'h0, done}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h0111, 1'b0, 16'h1345, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; A = '0; B = '0; sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'h0, ready}, 32'd1);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_result", {16'h0, result}, 32'd0);
        chk("rst_flags", {29'h0, ovfl, zero, neg}, 32'd0);
        rst = 1'b0;

        // table-driven vectors
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                   {vecs[i].res, vecs[i].v, vecs[i].z, vecs[i].n});
        end

        // random operations against the wide-arithmetic model
        for (int i = 0; i < 8; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rs;
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            rs = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", i), ra, rb, rs, model(ra, rb, rs));
        end

        // start held high: accepted once every 6 cycles, pulses in RUN/DONE ignored
        @(negedge clk);
        A = 16'h1111; B = 16'h2222; sub = 1'b0; start = 1'b1;
        repeat (3) exp_q.push_back({16'h3333, 1'b0, 1'b0, 1'b0});
        for (int n = 1; n <= 18; n++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_done", {31'h0, done}, (n % 6 == 5) ? 32'd1 : 32'd0);
            chk("hold_ready", {31'h0, ready}, (n % 6 == 0) ? 32'd1 : 32'd0);
            if (done) pop_compare("hold");
        end
        start = 1'b0;

        // reset mid-RUN: operation discarded, outputs cleared, no done
        @(negedge clk);
        A = 16'h4000; B = 16'h0123; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_busy", {31'h0, busy}, 32'd1);
        chk("mid_result_held", {16'h0, result}, 32'h3333);
        rst = 1'b1;
        #1;
        chk("arst_ready", {31'h0, ready}, 32'd1);
        chk("arst_busy", {31'h0, busy}, 32'd0);
        chk("arst_result", {16'h0, result}, 32'd0);
        chk("arst_flags", {29'h0, ovfl, zero, neg}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk);
            @(negedge clk);
            chk("arst_no_done", {31'h0, done}, 32'd0);
            chk("arst_idle", {31'h0, ready}, 32'd1);
        end

        run_op("post_rst", 16'h4000, 16'h0123, 1'b0, model(16'h4000, 16'h0123, 1'b0));

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_addsub16.md
Name: nibble_serial_addsub16

Overview:
Multi-cycle 16-bit signed add/subtract unit that drives one 4-bit add/sub slice. The slice is iterated over four nibbles, least-significant first, with the carry held between cycles.
It is the consumer side of the 4-bit add/sub interface and is used where area matters more than latency, for example the ALU's low-area datapath option.
It produces a saturating 16-bit result plus Z/V/N flags and uses a start/done handshake.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of SLICE
SLICE, 4, bits processed per cycle
SATURATE, 1, 1 = clamp on signed overflow; 0 = wrap

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request; sampled only while ready=1
A  in  WIDTH  operand A (two's complement)
B  in  WIDTH  operand B (two's complement)
sub  in  1  0: A+B, 1: A-B
ready  out  1  high in IDLE only
busy  out  1  high in RUN
done  out  1  one-cycle pulse; result and flags valid
result  out  WIDTH  sum/difference; held until next accepted start
ovfl  out  1  signed overflow of the unsaturated operation
zero  out  1  result == 0 (final, post-saturation value)
neg  out  1  result[WIDTH-1]

Behaviour:
- Reset (async, any state): state=IDLE, result=0, ovfl=0, zero=0, neg=0, done=0, busy=0, ready=1, idx=0, carry=0. An operation in flight is discarded and no done is issued.
- States: IDLE, RUN, DONE.
  - IDLE: on an edge with start=1, latch A, B, sub; carry<=sub; idx<=0; go to RUN. Otherwise stay.
  - RUN: each edge computes nibble idx.
    - s = A[idx] + (B[idx] ^ {SLICE{sub}}) + carry, computed SLICE+1 bits wide.
    - Write s[SLICE-1:0] into the working register at nibble idx; carry<=s[SLICE]; idx<=idx+1.
    - On the edge that processes the last nibble (idx=WIDTH/SLICE-1), go to DONE.
  - DONE: done=1 for exactly this cycle; next edge returns to IDLE.
- Latency: start is sampled at edge k; done is high during the cycle following edge k+WIDTH/SLICE (edge k+4 at defaults). Throughput is one operation per 6 cycles.
- start during RUN or DONE is ignored. The latched operands are unaffected, and A/B/sub may change freely after acceptance.
- Overflow: V = (carry into MSB) XOR (carry out of MSB), computed on the final nibble. ovfl is registered with the result.
- Saturation (SATURATE=1, V=1): result = 0x7FFF if the latched A[MSB]=0, else 0x8000. With SATURATE=0 the result wraps. ovfl reports V in both cases.
- zero and neg are derived from the final registered result and update on the same edge as result.
- Outputs result/ovfl/zero/neg are written only on the edge entering DONE. They hold stable through IDLE and the next RUN.
- Carry out of the MSB is discarded and has no port.

Decomposition:
- Package addsub16_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - localparams NSLICE = WIDTH/SLICE, SAT_POS = 16'h7FFF, SAT_NEG = 16'h8000
- Sub-module addsub_slice4: combinational a[3:0], b[3:0], cin, sub -> s[3:0], cout, c3 (carry into bit 3). It is instantiated once and fed muxed nibbles by idx.
- The top level holds the FSM, the operand registers, the carry flop, the result register and the flag logic.

Test Plan:
- 0x1234 + 0x0111, sub=0 -> result 0x1345, ovfl=0, zero=0, neg=0; done high exactly 4 cycles after the start edge, for one cycle; ready back to 1 the next cycle.
- Inter-nibble carry: 0x00FF + 0x0001 -> 0x0100. Also 0x0FFF + 0x0001 -> 0x1000, ovfl=0.
- Overflow: 0x7FFF + 0x0001 -> ovfl=1, result 0x7FFF (SATURATE=1) or 0x8000 (SATURATE=0).
- Overflow: 0x8000 - 0x0001 -> ovfl=1, result 0x8000, neg=1.
- Subtract to zero: 0x0005 - 0x0005 -> result 0x0000, zero=1, ovfl=0. Then 0x0003 - 0x0005 -> 0xFFFE, neg=1.
- Handshake and reset:
  - start held high continuously with fixed operands -> accepted once every 6 cycles; pulses during RUN/DONE are ignored; result matches the first latched operands.
  - rst asserted mid-RUN -> immediately ready=1, result=0, flags=0, and no done pulse.
